// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and frame-check helper for the receiver and downstream scancode decoders.
package ps2_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam int unsigned PS2_START      = 0;
   localparam int unsigned PS2_STOP       = 10;

   localparam logic [7:0] PS2_BREAK    = 8'hF0;
   localparam logic [7:0] PS2_EXTENDED = 8'hE0;

   typedef enum logic {
      RX_IDLE,
      RX_BITS
   } rx_state_t;

   // Frame bit 0 is start, 8:1 data LSB-first, 9 odd parity, 10 stop.
   function automatic logic frame_good(input logic [PS2_FRAME_BITS-1:0] f);
      return (f[PS2_START] == 1'b0) && (f[PS2_STOP] == 1'b1) && (^f[9:1] == 1'b1);
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side pop interface of the PS/2 receive FIFO.
interface ps2_rx_fifo_if;

   logic       nextdata;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   modport master (
      input  nextdata,
      output data,
      output ready,
      output overflow,
      output frame_err
   );

   modport slave (
      output nextdata,
      input  data,
      input  ready,
      input  overflow,
      input  frame_err
   );

endinterface

// File: rtl/ps2_sync_fifo.sv
// Byte FIFO with wrapping pointers and occupancy count; read data is combinational from the head slot.
module ps2_sync_fifo #(
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            storage [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) storage[wr_ptr] <= wr_data;
   end

   assign rd_data = storage[rd_ptr];
   assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: clock synchronizer, 11-bit frame deserializer with timeout,
// and a byte FIFO exposing data/ready/nextdata to the scancode consumer.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter int unsigned TIMEOUT    = 5000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   ps2_rx_fifo_if.master  bus
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [2:0]    sync;
   logic          fall;
   rx_state_t     state;
   logic [3:0]    bit_cnt;
   logic [9:0]    shift;
   logic [TW-1:0] to_cnt;
   logic          push;
   logic [7:0]    push_byte;
   logic          frame_err_r;
   logic          overflow_r;
   logic          pop;
   logic          wr_ok;
   logic          full;
   logic          empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 3'b111;
      else     sync <= {sync[1:0], ps2_clk};
   end

   assign fall = (sync[2:1] == 2'b10);

   // ps2_data is taken straight from the pin: the device holds it stable across the whole low phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RX_IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         to_cnt      <= '0;
         push        <= 1'b0;
         push_byte   <= '0;
         frame_err_r <= 1'b0;
      end else begin
         push        <= 1'b0;
         frame_err_r <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'(PS2_STOP)) begin
               bit_cnt <= '0;
               state   <= RX_IDLE;
               if (frame_good({ps2_data, shift})) begin
                  push      <= 1'b1;
                  push_byte <= shift[8:1];
               end else begin
                  frame_err_r <= 1'b1;
               end
            end else begin
               shift[bit_cnt] <= ps2_data;
               bit_cnt        <= bit_cnt + 1'b1;
               state          <= RX_BITS;
            end
         end else if (state == RX_BITS) begin
            if (to_cnt == TW'(TIMEOUT - 1)) begin
               to_cnt      <= '0;
               bit_cnt     <= '0;
               state       <= RX_IDLE;
               frame_err_r <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

   assign pop   = bus.nextdata && !empty;
   assign wr_ok = push && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       overflow_r <= 1'b0;
      else if (push && full && !pop) overflow_r <= 1'b1;
   end

   ps2_sync_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok),
      .wr_data (push_byte),
      .rd_en   (pop),
      .rd_data (bus.data),
      .full    (full),
      .empty   (empty)
   );

   assign bus.ready     = !empty;
   assign bus.overflow  = overflow_r;
   assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table, directed corner sequences, random frames vs queue model.
module tb_ps2_rx_fifo;

   localparam int unsigned TO = 300;

   logic clk = 1'b0;
   logic rst;
   logic ps2_clk;
   logic ps2_data;

   ps2_rx_fifo_if bus();

   ps2_rx_fifo #(
      .DEPTH_LOG2(3),
      .TIMEOUT   (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int total   = 0;
   int bad     = 0;
   int err_cnt = 0;
   int exp_err = 0;
   logic ovf_exp = 1'b0;
   byte unsigned q[$];

   always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

   typedef struct {
      byte unsigned d;
      bit bpar;
      bit bstop;
      bit bstart;
      bit exp_err;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] mk(input byte unsigned d, input bit bpar, input bit bstop,
                                      input bit bstart);
      logic [10:0] f;
      f[0]   = bstart;
      f[8:1] = d;
      f[9]   = ~(^d) ^ bpar;
      f[10]  = ~bstop;
      return f;
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         repeat (8) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (8) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   // Model: good bytes queue up to 8 deep, extras set the sticky overflow; bad frames count an error.
   task automatic send(input byte unsigned d, input bit bpar, input bit bstop, input bit bstart);
      send_bits(mk(d, bpar, bstop, bstart), 11);
      repeat (4) @(negedge clk);
      if (bpar || bstop || bstart) exp_err++;
      else if (q.size() < 8) q.push_back(d);
      else ovf_exp = 1'b1;
   endtask

   task automatic pop_one(input string name);
      chk({name, "_ready"}, int'(bus.ready), int'(q.size() != 0));
      if (q.size() != 0) chk({name, "_data"}, int'(bus.data), int'(q[0]));
      bus.nextdata = 1'b1;
      @(negedge clk);
      bus.nextdata = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      chk({name, "_ready_after"}, int'(bus.ready), int'(q.size() != 0));
   endtask

   initial begin
      logic [10:0] f;
      int e0;

      tbl[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{8'h32, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      bus.nextdata = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ready", int'(bus.ready), 0);
      chk("reset_overflow", int'(bus.overflow), 0);
      chk("reset_frame_err", int'(bus.frame_err), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 0x1C: ready must rise exactly 4 clk after the 11th falling edge
      f = mk(8'h1C, 1'b0, 1'b0, 1'b0);
      send_bits(f, 10);
      ps2_data = f[10];
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      chk("lat_ready_3clk", int'(bus.ready), 0);
      @(negedge clk);
      chk("lat_ready_4clk", int'(bus.ready), 1);
      chk("lat_data", int'(bus.data), 8'h1C);
      chk("lat_no_err", err_cnt, 0);
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      q.push_back(8'h1C);
      pop_one("t1_pop");

      for (int i = 0; i < 8; i++) begin
         e0 = err_cnt;
         send(tbl[i].d, tbl[i].bpar, tbl[i].bstop, tbl[i].bstart);
         chk($sformatf("vec%0d_err", i), err_cnt - e0, int'(tbl[i].exp_err));
         chk($sformatf("vec%0d_ready", i), int'(bus.ready), int'(q.size() != 0));
         if (q.size() != 0) chk($sformatf("vec%0d_head", i), int'(bus.data), int'(q[0]));
      end
      while (q.size() != 0) pop_one("vec_drain");

      send(8'hF0, 1'b0, 1'b0, 1'b0);
      send(8'h1C, 1'b0, 1'b0, 1'b0);
      send(8'hE0, 1'b0, 1'b0, 1'b0);
      send(8'h75, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pop_one($sformatf("order%0d", i));

      // partial frame abandoned by the timeout
      send_bits(mk(8'hAA, 1'b0, 1'b0, 1'b0), 5);
      e0 = err_cnt;
      repeat (TO - 30) @(negedge clk);
      chk("timeout_early", err_cnt - e0, 0);
      repeat (60) @(negedge clk);
      chk("timeout_fire", err_cnt - e0, 1);
      exp_err++;
      send(8'h29, 1'b0, 1'b0, 1'b0);
      pop_one("after_timeout");

      for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
      chk("ovf_set", int'(bus.overflow), int'(ovf_exp));
      for (int i = 0; i < 8; i++) pop_one($sformatf("ovf_pop%0d", i));
      chk("ovf_empty", int'(bus.ready), 0);
      chk("ovf_sticky", int'(bus.overflow), 1);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      q.delete();
      ovf_exp = 1'b0;
      chk("rst_clears_ovf", int'(bus.overflow), 0);

      // full FIFO, pop lands on the same edge as the 9th write
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      f = mk(8'h18, 1'b0, 1'b0, 1'b0);
      send_bits(f, 10);
      ps2_data = f[10];
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      chk("samecyc_head", int'(bus.data), 8'h10);
      bus.nextdata = 1'b1;
      @(negedge clk);
      bus.nextdata = 1'b0;
      void'(q.pop_front());
      q.push_back(8'h18);
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      chk("samecyc_no_ovf", int'(bus.overflow), 0);
      for (int i = 0; i < 8; i++) pop_one($sformatf("samecyc_pop%0d", i));
      chk("samecyc_empty", int'(bus.ready), 0);

      send(8'h21, 1'b0, 1'b0, 1'b0);
      send(8'h22, 1'b0, 1'b0, 1'b0);
      send_bits(mk(8'h23, 1'b0, 1'b0, 1'b0), 4);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      q.delete();
      chk("midrst_ready", int'(bus.ready), 0);
      chk("midrst_ovf", int'(bus.overflow), 0);
      send(8'h4B, 1'b0, 1'b0, 1'b0);
      pop_one("midrst_next");

      for (int r = 0; r < 40; r++) begin
         int kind;
         int npop;
         byte unsigned d;
         kind = $urandom_range(0, 9);
         d = 8'($urandom_range(0, 255));
         send(d, kind == 0, kind == 1, 1'b0);
         chk($sformatf("rnd%0d_err", r), err_cnt, exp_err);
         chk($sformatf("rnd%0d_ovf", r), int'(bus.overflow), int'(ovf_exp));
         npop = $urandom_range(0, 2);
         for (int p = 0; p < npop; p++) pop_one($sformatf("rnd%0d_pop", r));
      end
      while (q.size() != 0) pop_one("rnd_drain");
      chk("final_err_count", err_cnt, exp_err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
